// File: rtl/frog_round_ctrl_pkg.sv
// Shared types and width helpers for the Frogger round/lives sequencer.
package frog_pkg;

   // FSM state encoding; the numeric values are also what the state debug output shows.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PLAY   = 3'd1,
      SCORED = 3'd2,
      HIT    = 3'd3,
      OVER   = 3'd4,
      WIN    = 3'd5
   } state_t;

   // Bits needed to hold a counter value in 0..n (at least one bit).
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   // Widths for the default configuration (WIN_SCORE=17, HOLD_CYCLES=8).
   // The controller re-derives the counter widths from its own parameters.
   localparam int LIVES_W = 3;
   localparam int TALLY_W = $clog2(17 + 1);
   localparam int HOLD_W  = $clog2(8 + 1);

endpackage

// File: rtl/frog_round_ctrl_if.sv
// Signal bundle between the game top level and the round controller.
interface frog_round_ctrl_if;
   import frog_pkg::*;

   // Game inputs
   logic               start;
   logic               up;
   logic [15:0]        topRow;
   logic               collision;

   // Controller outputs
   logic               score_pulse;
   logic               respawn;
   logic               freeze;
   logic [LIVES_W-1:0] lives;
   logic               game_over;
   logic               win;
   logic [2:0]         state;

   // Side that drives the game inputs and observes the controller.
   modport master (
      output start, up, topRow, collision,
      input  score_pulse, respawn, freeze, lives, game_over, win, state
   );

   // The round controller itself.
   modport slave (
      input  start, up, topRow, collision,
      output score_pulse, respawn, freeze, lives, game_over, win, state
   );

endinterface

// File: rtl/frog_round_ctrl_edge_rise.sv
// Rising-edge detector: one register plus an AND, cleared asynchronously.
module edge_rise (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic rise_o
);

   logic d_q;

   // Remember last cycle's level so a held input only produces one pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) d_q <= 1'b0;
      else        d_q <= d_i;
   end

   assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/frog_round_ctrl.sv
// Round/lives sequencer for Frogger: turns key edges, top-row occupancy and
// car hits into score/respawn strobes, tracks lives and crossings, and holds
// the playfield frozen for a fixed time after every score or hit.
module frog_round_ctrl
   import frog_pkg::*;
#(
   parameter int LIVES       = 3,
   parameter int WIN_SCORE   = 17,
   parameter int HOLD_CYCLES = 8
) (
   input  logic               clk,
   input  logic               reset,
   frog_round_ctrl_if.slave   bus
);

   localparam int TALLY_BITS = cnt_w(WIN_SCORE);
   localparam int HOLD_BITS  = cnt_w(HOLD_CYCLES);

   localparam logic [LIVES_W-1:0]    LIVES_INIT = LIVES_W'(LIVES);
   localparam logic [LIVES_W-1:0]    LIFE_ONE   = LIVES_W'(1);
   localparam logic [TALLY_BITS-1:0] WIN_TALLY  = TALLY_BITS'(WIN_SCORE);
   localparam logic [HOLD_BITS-1:0]  HOLD_LOAD  = HOLD_BITS'(HOLD_CYCLES);
   localparam logic [HOLD_BITS-1:0]  HOLD_ONE   = HOLD_BITS'(1);

   state_t                state_q;
   logic [LIVES_W-1:0]    lives_q;
   logic [TALLY_BITS-1:0] tally_q;
   logic [HOLD_BITS-1:0]  hold_q;
   logic                  score_pulse_q;
   logic                  respawn_q;
   logic                  freeze_q;
   logic                  game_over_q;
   logic                  win_q;

   logic                  up_rise;
   logic                  start_rise;
   logic                  on_top;
   logic [TALLY_BITS-1:0] tally_d;

   edge_rise u_up_rise (
      .clk    (clk),
      .rst_n  (reset),
      .d_i    (bus.up),
      .rise_o (up_rise)
   );

   edge_rise u_start_rise (
      .clk    (clk),
      .rst_n  (reset),
      .d_i    (bus.start),
      .rise_o (start_rise)
   );

   assign on_top  = |bus.topRow;
   // Tally after a successful crossing; the FSM leaves PLAY when this hits
   // WIN_SCORE, so it never needs to exceed that value.
   assign tally_d = tally_q + TALLY_BITS'(1);

   // Round FSM with lives, tally and hold counters and all registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         lives_q       <= '0;
         tally_q       <= '0;
         hold_q        <= '0;
         score_pulse_q <= 1'b0;
         respawn_q     <= 1'b0;
         freeze_q      <= 1'b1;
         game_over_q   <= 1'b0;
         win_q         <= 1'b0;
      end else begin
         // Strobes are single-cycle unless a branch below re-asserts them.
         score_pulse_q <= 1'b0;
         respawn_q     <= 1'b0;

         unique case (state_q)
            IDLE, OVER, WIN: begin
               // A fresh game starts identically from any of the idle states.
               if (start_rise) begin
                  state_q     <= PLAY;
                  lives_q     <= LIVES_INIT;
                  tally_q     <= '0;
                  hold_q      <= '0;
                  respawn_q   <= 1'b1;
                  freeze_q    <= 1'b0;
                  game_over_q <= 1'b0;
                  win_q       <= 1'b0;
               end
            end

            PLAY: begin
               if (bus.collision) begin
                  // A hit always wins over a simultaneous score.
                  freeze_q <= 1'b1;
                  if (lives_q <= LIFE_ONE) begin
                     // Last life gone: no hold, no respawn, straight to OVER.
                     lives_q     <= '0;
                     state_q     <= OVER;
                     game_over_q <= 1'b1;
                  end else begin
                     lives_q <= lives_q - LIFE_ONE;
                     hold_q  <= HOLD_LOAD;
                     state_q <= HIT;
                  end
               end else if (up_rise && on_top) begin
                  score_pulse_q <= 1'b1;
                  tally_q       <= tally_d;
                  freeze_q      <= 1'b1;
                  if (tally_d == WIN_TALLY) begin
                     state_q <= WIN;
                     win_q   <= 1'b1;
                  end else begin
                     hold_q  <= HOLD_LOAD;
                     state_q <= SCORED;
                  end
               end
            end

            SCORED, HIT: begin
               // Hold counts HOLD_CYCLES..1; the cycle after 1 is back in play.
               if (hold_q <= HOLD_ONE) begin
                  hold_q    <= '0;
                  state_q   <= PLAY;
                  respawn_q <= 1'b1;
                  freeze_q  <= 1'b0;
               end else begin
                  hold_q <= hold_q - HOLD_ONE;
               end
            end

            default: begin
               // Unused encodings recover to a frozen IDLE.
               state_q     <= IDLE;
               freeze_q    <= 1'b1;
               game_over_q <= 1'b0;
               win_q       <= 1'b0;
            end
         endcase
      end
   end

   assign bus.score_pulse = score_pulse_q;
   assign bus.respawn     = respawn_q;
   assign bus.freeze      = freeze_q;
   assign bus.lives       = lives_q;
   assign bus.game_over   = game_over_q;
   assign bus.win         = win_q;
   assign bus.state       = state_q;

endmodule

// File: doc/frog_round_ctrl.md
Name: frog_round_ctrl

Overview:
- Round/lives sequencer for the Frogger game.
- Watches the frog's top-row occupancy, the up key and the car-collision flag.
- Emits one-cycle score_pulse strobes to the score counter and respawn strobes to the frog-position logic.
- Owns the lives tally, a freeze hold after each event, and the win/game-over decision.

Parameters:
- LIVES, 3, lives loaded at game start (1..7).
- WIN_SCORE, 17, number of successful crossings that ends the game in WIN (1..255).
- HOLD_CYCLES, 8, freeze length after a score or hit, in clk cycles (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset; the block is cleared whenever reset is 0.
- start  in  1  level; a rising edge begins a game from IDLE, OVER or WIN.
- up  in  1  up-key level (already synchronised); rising edge detected internally.
- topRow  in  16  frog occupancy of the top lane; nonzero means the frog is on the top row.
- collision  in  1  level; frog overlaps a car this cycle.
- score_pulse  out  1  one-cycle strobe; the downstream score counter increments on it.
- respawn  out  1  one-cycle strobe; the frog returns to its start cell.
- freeze  out  1  high while the lanes and frog must hold still.
- lives  out  3  remaining lives.
- game_over  out  1  high in OVER.
- win  out  1  high in WIN.
- state  out  3  current FSM state encoding, for debug/LEDs.

Behaviour:
- Reset (reset=0, async) values:
  - state=IDLE, lives=0, tally=0, hold count=0.
  - All strobes 0, freeze=1, game_over=0, win=0.
  - Edge-detect registers (up, start) cleared to 0.
- Edge detect: up_rise = up & ~up_q, where up_q is up registered; start_rise formed the same way.
- States: IDLE, PLAY, SCORED, HIT, OVER, WIN.
- IDLE: freeze=1. On start_rise: lives<=LIVES, tally<=0, go to PLAY; respawn=1 that same cycle (Moore on the transition, registered output).
- PLAY: freeze=0. Priority order each cycle:
  1. collision=1: lives<=lives-1, hold<=HOLD_CYCLES, go to HIT. If lives was 1, go to OVER instead; lives becomes 0 and no hold is loaded.
  2. else up_rise & (topRow!=0): score_pulse=1, tally<=tally+1, hold<=HOLD_CYCLES, go to SCORED. If tally+1==WIN_SCORE, go to WIN instead.
  3. else remain in PLAY.
- SCORED and HIT: freeze=1; hold decrements by 1 each cycle. When hold reaches 1, the next cycle enters PLAY with respawn=1 for one cycle. Dwell is exactly HOLD_CYCLES cycles. collision and up are ignored here.
- OVER: game_over=1, freeze=1; start_rise restarts exactly as from IDLE.
- WIN: win=1, freeze=1; start_rise restarts exactly as from IDLE.
- Strobe timing: all outputs are registered. score_pulse and respawn are high for exactly one cycle, the cycle after the triggering input edge is sampled.
- Collision beats score in the same cycle. A single held up produces at most one score (edge-based).
- Wrap/saturation:
  - lives never decrements below 0.
  - tally never exceeds WIN_SCORE, since the block leaves PLAY at equality.
  - hold is never loaded with 0.
- Reset asserted mid-hold or mid-game clears immediately; no strobe is emitted on deassert. The first start_rise after deassert must be a genuine 0->1 transition seen after reset.

Decomposition:
- Package frog_pkg holds:
  - enum state_t (IDLE=0, PLAY=1, SCORED=2, HIT=3, OVER=4, WIN=5);
  - localparam widths: LIVES_W=3, TALLY_W=$clog2(WIN_SCORE+1), HOLD_W=$clog2(HOLD_CYCLES+1).
- One sub-module, edge_rise, instanced twice (up, start): 1-bit register plus AND, async active-low clear.
- The FSM, lives, tally and hold counters live in frog_round_ctrl itself.

Test Plan (LIVES=3, WIN_SCORE=3, HOLD_CYCLES=4):
- Reset, then start 0->1 -> PLAY, lives=3, respawn high 1 cycle, freeze=0, score_pulse=0.
- In PLAY, topRow=16'h0100 and up held high 5 cycles -> exactly 1 score_pulse, state SCORED for 4 cycles, then PLAY with respawn=1; up held with topRow=0 -> no pulse.
- Three scoring crossings -> 3 score_pulse total, state=WIN, win=1, freeze=1; further up edges produce no pulse.
- collision in PLAY with lives=3 -> HIT, lives=2, 4 freeze cycles, respawn; collision while in HIT ignored (lives stays 2); repeat hits until lives=0 -> OVER, game_over=1, no respawn.
- Same cycle collision=1 and up_rise with topRow=16'h0001 -> HIT, lives decremented, no score_pulse.
- reset low during SCORED with hold=2 -> immediate IDLE, lives=0, freeze=1; after release, start_rise -> PLAY with lives=3, tally=0.
